// File: rtl/hex_scan_controller.sv
// hex_scan_controller: time-shares one external 7-segment decoder across NUM_DIGITS HEX digits
//   clk, rst_n        : clock, asynchronous active-low reset
//   valor_in/valid/ready : new display value, accepted by valid/ready, applied at the next frame start
//   blank_zeros       : suppress leading zeros (digit 0 always shown)
//   blink_mask        : per-digit blink enable
//   nibble_out/seg_in : request/response with the shared combinational decoder
//   hex_out           : registered active-low segments, 7 bits per digit
//   frame_done        : one-cycle pulse when digit 0 is written
module hex_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] valor_in,
    input  logic                    valor_valid,
    output logic                    valor_ready,
    input  logic                    blank_zeros,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [3:0]              nibble_out,
    input  logic [6:0]              seg_in,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    frame_done
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int WW = $clog2(SCAN_DIV);
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [WW-1:0] WAIT_LD  = WW'(SCAN_DIV - 3);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {LOAD, DRIVE, CAPTURE, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d, pend_q, pend_d;
    logic                    pflag_q, pflag_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [WW-1:0]           wcnt_q, wcnt_d;
    logic                    seen_q, seen_d;
    logic [3:0]              nib_q, nib_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    fd_q, fd_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    phase_q, phase_d;
    logic                    dark;

    assign valor_ready = !pflag_q;
    assign nibble_out  = nib_q;
    assign hex_out     = hex_q;
    assign frame_done  = fd_q;

    // blink has priority over zero suppression; both force the digit dark
    assign dark = (blink_mask[idx_q] & phase_q) |
                  (blank_zeros & !seen_q & (nib_q == 4'd0) & (idx_q != '0));

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        pflag_d  = pflag_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        seen_d   = seen_q;
        nib_d    = nib_q;
        hex_d    = hex_q;
        fd_d     = 1'b0;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        // ready is the inverse of the pending flag, so accept and consume never coincide
        if (valor_valid && !pflag_q) begin
            pend_d  = valor_in;
            pflag_d = 1'b1;
        end
        unique case (state_q)
            LOAD: begin
                if (pflag_q) begin
                    active_d = pend_q;
                    pflag_d  = 1'b0;
                end
                seen_d  = 1'b0;
                idx_d   = LAST_IDX;
                state_d = DRIVE;
            end
            DRIVE: begin
                nib_d   = active_q[4*idx_q +: 4];
                state_d = CAPTURE;
            end
            CAPTURE: begin
                hex_d[7*idx_q +: 7] = dark ? 7'h7F : seg_in;
                seen_d  = seen_q | (nib_q != 4'd0);
                wcnt_d  = WAIT_LD;
                state_d = WAIT;
                if (idx_q == '0) begin
                    fd_d    = 1'b1;
                    bcnt_d  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
                    phase_d = phase_q ^ (bcnt_q == BLINK_LAST);
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = (idx_q == '0) ? LOAD : DRIVE;
                    idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            active_q <= '0;
            pend_q   <= '0;
            pflag_q  <= 1'b0;
            idx_q    <= LAST_IDX;
            wcnt_q   <= '0;
            seen_q   <= 1'b0;
            nib_q    <= 4'd0;
            hex_q    <= '1;
            fd_q     <= 1'b0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pflag_q  <= pflag_d;
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            seen_q   <= seen_d;
            nib_q    <= nib_d;
            hex_q    <= hex_d;
            fd_q     <= fd_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
        end
    end
endmodule

// File: tb/tb_hex_scan_controller.sv
// tb_hex_scan_controller: randomized self-checking bench for hex_scan_controller against a frame-level model
module tb_hex_scan_controller;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int B  = 2;
    localparam int FL = 1 + N * SD;
    // cycles after release until frame_done is seen: LOAD, N-1 full slots, then DRIVE+CAPTURE of digit 0
    localparam int FD_AT = 1 + (N - 1) * SD + 2;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          clk, rst_n;
    logic [4*N-1:0] valor_in;
    logic          valor_valid, valor_ready, blank_zeros, frame_done;
    logic [N-1:0]  blink_mask;
    logic [3:0]    nibble_out;
    logic [6:0]    seg_in;
    logic [7*N-1:0] hex_out;

    int n_chk = 0, n_pass = 0;
    int m_n;
    logic [4*N-1:0] m_act, m_pend;
    logic m_pf;

    hex_scan_controller #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(B)) dut (
        .clk(clk), .rst_n(rst_n), .valor_in(valor_in), .valor_valid(valor_valid),
        .valor_ready(valor_ready), .blank_zeros(blank_zeros), .blink_mask(blink_mask),
        .nibble_out(nibble_out), .seg_in(seg_in), .hex_out(hex_out), .frame_done(frame_done)
    );

    assign seg_in = SEG[nibble_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7*N-1:0] exp_hex(input logic [4*N-1:0] v, input logic bz,
                                               input logic [N-1:0] m, input logic ph);
        logic [7*N-1:0] h;
        for (int i = 0; i < N; i++)
            h[7*i +: 7] = (m[i] && ph) ? 7'h7F :
                          (bz && i != 0 && (v >> (4*i)) == 0) ? 7'h7F : SEG[v[4*i +: 4]];
        return h;
    endfunction

    // transaction model: frames start every FL cycles after release; a value is
    // taken when ready, and becomes active at the first frame start after it was taken
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_act = '0; m_pend = '0; m_pf = 1'b0;
        end else begin
            logic tr;
            tr = valor_valid && !m_pf;
            if (m_n % FL == 0 && m_pf) begin m_act = m_pend; m_pf = 1'b0; end
            if (tr) begin m_pend = valor_in; m_pf = 1'b1; end
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int p;
            p = m_n % FL;
            chk("ready", 32'(valor_ready), 32'(!m_pf));
            chk("frame_done", 32'(frame_done), 32'(m_n > 0 && p == FD_AT % FL));
            if (m_n > 0 && p == FD_AT % FL)
                chk("frame_hex", 32'(hex_out),
                    32'(exp_hex(m_act, blank_zeros, blink_mask, 1'(((m_n / FL) / B) % 2))));
            if (p >= 2 && (p - 2) % SD == 0)
                chk("nibble", 32'(nibble_out), 32'(m_act[4*(N - 1 - (p - 2) / SD) +: 4]));
        end
    end

    task automatic wait_fd();
        int t = 0;
        @(negedge clk);
        while (!frame_done && t < 2 * FL) begin @(negedge clk); t++; end
        chk("fd_wait", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_load();
        int t = 0;
        @(negedge clk);
        while (m_n % FL != 0 && t < 2 * FL) begin @(negedge clk); t++; end
        chk("load_wait", 32'(m_n % FL), 32'd0);
    endtask

    task automatic send(input logic [4*N-1:0] v);
        int t = 0;
        @(negedge clk);
        valor_in = v;
        valor_valid = 1'b1;
        while (!valor_ready && t < 3 * FL) begin @(negedge clk); t++; end
        chk("send_ready", 32'(valor_ready), 32'd1);
        @(negedge clk);
        valor_valid = 1'b0;
    endtask

    // config changes land right after a frame_done so a whole frame sees one setting
    task automatic set_cfg(input logic bz, input logic [N-1:0] m);
        wait_fd();
        @(negedge clk);
        blank_zeros = bz;
        blink_mask = m;
    endtask

    task automatic show(input string tag, input logic [4*N-1:0] v, input logic [7*N-1:0] exp);
        send(v);
        wait_fd();
        wait_fd();
        chk(tag, 32'(hex_out), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; valor_valid = 1'b0; valor_in = '0; blank_zeros = 1'b0; blink_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_hex", 32'(hex_out), 32'h0FFF_FFFF);
        chk("rst_ready", 32'(valor_ready), 32'd1);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_nibble", 32'(nibble_out), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        show("val_1234", 16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        set_cfg(1'b1, '0);
        show("blank_0070", 16'h0070, {7'h7F, 7'h7F, 7'b1111000, 7'b1000000});
        show("blank_0000", 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
        show("blank_0F00", 16'h0F00, {7'h7F, 7'b0001110, 7'b1000000, 7'b1000000});
        set_cfg(1'b0, 4'b0001);
        send(16'h0008);
        repeat (6) wait_fd();
        set_cfg(1'b0, '0);
        wait_fd();
        wait_load();
        valor_in = 16'h4321;
        valor_valid = 1'b1;
        @(negedge clk);
        valor_in = 16'hAAAA;
        repeat (5) @(negedge clk);
        valor_valid = 1'b0;
        wait_fd();
        wait_fd();
        chk("load_xfer", 32'(hex_out), 32'(exp_hex(16'h4321, 1'b0, '0, 1'b0)));
        wait_load();
        @(negedge clk);
        valor_in = 16'h9999;
        valor_valid = 1'b1;
        @(negedge clk);
        valor_valid = 1'b0;
        while (m_n % FL != 2 * SD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hex", 32'(hex_out), 32'h0FFF_FFFF);
        chk("mid_rst_ready", 32'(valor_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fd();
        wait_fd();
        chk("rst_discard", 32'(hex_out), 32'(exp_hex('0, 1'b0, '0, 1'b0)));
        for (int k = 0; k < 12; k++) begin
            set_cfg(1'($urandom), N'($urandom));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(16'($urandom) >> (4 * $urandom_range(0, 4)));
            wait_fd();
            wait_fd();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached limit 200000", $time);
        $fatal(1);
    end
endmodule
